// File: rtl/meas_result_fifo.sv
`default_nettype none
// ============================================================================
// meas_result_fifo : measurement record capture into a FWFT FIFO, with stats.
// Optional I/Q payload in the record: define MEAS_RESULT_IQ_EN.   Rev 1.0
// ============================================================================
module meas_result_fifo #(
  parameter int AW = 6,
  parameter int TW = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               done,
  input  logic signed [31:0] xacc,
  input  logic signed [31:0] yacc,
  input  logic               resultx,
  input  logic               resulty,
  input  logic               tsclear,
  input  logic               statclr,
  output logic [63:0]        rdata,
  output logic               rvalid,
  input  logic               rready,
  output logic [AW:0]        count,
  output logic               overflow,
  output logic [15:0]        dropped,
  output logic [31:0]        shots,
  output logic [31:0]        onesx,
  output logic [31:0]        onesy
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE_CNT  = {{AW{1'b0}}, 1'b1};
`ifdef MEAS_RESULT_IQ_EN
  localparam int RW = 64;
`else
  localparam int RW = 32;
`endif

  logic [TW-1:0] ts_q, ts_d, ts_now;
  logic          pend_q;
  logic [TW-1:0] tsl_q;
  logic [RW-1:0] rec;

  logic [RW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q, rp_nxt;
  logic [AW:0]   count_q, count_d;
  logic [RW-1:0] head_q, head_d;
  logic          empty, full, pop, push, drop;

  logic          overflow_q;
  logic [15:0]   dropped_q, dropped_d;
  logic [31:0]   shots_q, shots_d, onesx_q, onesx_d, onesy_q, onesy_d;

  // A tsclear in the done cycle must already stamp that record with zero.
  assign ts_now = tsclear ? '0 : ts_q;
  assign ts_d   = tsclear ? '0 : ts_q + TW'(1);

`ifdef MEAS_RESULT_IQ_EN
  logic [15:0] xl_q, yl_q;
  logic        w_unused_lo;
  assign w_unused_lo = ^{xacc[15:0], yacc[15:0]};

  always_ff @(posedge clk) begin
    if (done) begin
      xl_q <= xacc[31:16];
      yl_q <= yacc[31:16];
    end
  end

  assign rec   = {xl_q, yl_q, tsl_q, resulty, resultx};
  assign rdata = head_q;
`else
  logic w_unused_iq;
  assign w_unused_iq = ^{xacc, yacc};
  assign rec   = {tsl_q, resulty, resultx};
  assign rdata = {32'h0, head_q};
`endif

  always_ff @(posedge clk) begin
    if (done) tsl_q <= ts_now;
  end

  assign empty  = (count_q == '0);
  assign full   = (count_q == FULL_CNT);
  assign pop    = !empty && rready;
  assign push   = pend_q && (!full || pop);
  assign drop   = pend_q && full && !pop;
  assign rp_nxt = rp_q + AW'(1);

  always_comb begin
    head_d = head_q;
    if (pop) begin
      if (count_q > ONE_CNT) head_d = mem_q[rp_nxt];
      else if (push)         head_d = rec;
    end else if (push && empty) begin
      head_d = rec;
    end
  end

  always_comb begin
    count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
    dropped_d = dropped_q;
    if (drop && dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
    shots_d = shots_q;
    onesx_d = onesx_q;
    onesy_d = onesy_q;
    // A clear in the stage-B cycle wins over counting that shot.
    if (statclr) begin
      shots_d = '0;
      onesx_d = '0;
      onesy_d = '0;
    end else if (pend_q) begin
      shots_d = shots_q + 32'd1;
      onesx_d = onesx_q + 32'(resultx);
      onesy_d = onesy_q + 32'(resulty);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= rec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q       <= '0;
      pend_q     <= 1'b0;
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      head_q     <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
      shots_q    <= '0;
      onesx_q    <= '0;
      onesy_q    <= '0;
    end else begin
      ts_q       <= ts_d;
      pend_q     <= done;
      count_q    <= count_d;
      head_q     <= head_d;
      dropped_q  <= dropped_d;
      shots_q    <= shots_d;
      onesx_q    <= onesx_d;
      onesy_q    <= onesy_d;
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_nxt;
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign rvalid   = !empty;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign dropped  = dropped_q;
  assign shots    = shots_q;
  assign onesx    = onesx_q;
  assign onesy    = onesy_q;

endmodule
`default_nettype wire

// File: tb/tb_meas_result_fifo.sv
`default_nettype none
// ============================================================================
// tb_meas_result_fifo : table vectors, corner sequences and random traffic
// against a queue-based record model.                               Rev 1.0
// ============================================================================
module tb_meas_result_fifo;

  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, done, resultx, resulty, tsclear, statclr, rready;
  logic [31:0] xacc, yacc;
  logic [63:0] rdata;
  logic        rvalid, overflow;
  logic [AW:0] count;
  logic [15:0] dropped;
  logic [31:0] shots, onesx, onesy;

  always #5 clk = ~clk;

  meas_result_fifo #(.AW(AW), .TW(30)) dut (
    .clk(clk), .reset(reset), .done(done), .xacc(xacc), .yacc(yacc),
    .resultx(resultx), .resulty(resulty), .tsclear(tsclear), .statclr(statclr),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .count(count),
    .overflow(overflow), .dropped(dropped), .shots(shots), .onesx(onesx),
    .onesy(onesy)
  );

  typedef struct {
    bit rst, done, rx, ry, rdy, sclr, tclr;
    logic [31:0] x, y;
  } in_t;

  typedef struct {
    in_t i;
    bit chk, rvalid;
    int cnt, shots, ox, oy;
    logic [63:0] rd;
  } vec_t;

  int nvec  = 0;
  int nfail = 0;

  // Reference model: records as whole 64-bit words in a bounded queue.
  logic [63:0] mq[$];
  bit [29:0]   m_ts, m_pts;
  bit          m_pend, m_ovf;
  bit [15:0]   m_x, m_y;
  int          m_drop;
  bit [31:0]   m_shots, m_ox, m_oy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] vis(input logic [63:0] r);
`ifdef MEAS_RESULT_IQ_EN
    return r;
`else
    return {32'h0, r[31:0]};
`endif
  endfunction

  function automatic logic [63:0] mkrec(input logic [15:0] xh, input logic [15:0] yh,
                                        input int ts, input bit ry, input bit rx);
    logic [29:0] t;
    t = 30'(ts);
    return {xh, yh, t, ry, rx};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ts = '0; m_pend = 0; m_ovf = 0; m_drop = 0;
    m_shots = '0; m_ox = '0; m_oy = '0;
  endtask

  task automatic model_check();
    check("m_rvalid", 64'(rvalid), 64'(mq.size() != 0));
    check("m_count", 64'(count), 64'(mq.size()));
    if (mq.size() != 0) check("m_rdata", rdata, vis(mq[0]));
    check("m_overflow", 64'(overflow), 64'(m_ovf));
    check("m_dropped", 64'(dropped), 64'(m_drop));
    check("m_shots", 64'(shots), 64'(m_shots));
    check("m_onesx", 64'(onesx), 64'(m_ox));
    check("m_onesy", 64'(onesy), 64'(m_oy));
  endtask

  task automatic model_advance(input in_t s);
    bit pop, full;
    if (s.rst) begin
      model_reset();
    end else begin
      pop  = (mq.size() != 0) && s.rdy;
      full = (mq.size() == DEPTH);
      if (pop) void'(mq.pop_front());
      if (m_pend) begin
        if (!full || pop) mq.push_back({m_x, m_y, m_pts, s.ry, s.rx});
        else begin
          m_ovf = 1;
          if (m_drop != 65535) m_drop++;
        end
      end
      if (s.sclr) begin
        m_shots = '0; m_ox = '0; m_oy = '0;
      end else if (m_pend) begin
        m_shots += 1; m_ox += 32'(s.rx); m_oy += 32'(s.ry);
      end
      if (s.done) begin
        m_x   = s.x[31:16];
        m_y   = s.y[31:16];
        m_pts = s.tclr ? 30'd0 : m_ts;
      end
      m_pend = s.done;
      m_ts   = s.tclr ? 30'd0 : m_ts + 30'd1;
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance both.
  task automatic step(input in_t s);
    reset = s.rst; done = s.done; xacc = s.x; yacc = s.y;
    resultx = s.rx; resulty = s.ry; rready = s.rdy;
    statclr = s.sclr; tsclear = s.tclr;
    model_check();
    model_advance(s);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; done = 0; xacc = '0; yacc = '0; resultx = 0; resulty = 0;
    rready = 0; statclr = 0; tsclear = 0;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  vec_t v[24];
  in_t  cur;
  int   hits;

  initial begin
    for (int i = 0; i < 24; i++) begin
      v[i].i = '{default: 0};
      v[i].chk = 0; v[i].rvalid = 0; v[i].cnt = 0;
      v[i].shots = 0; v[i].ox = 0; v[i].oy = 0; v[i].rd = '0;
    end
    for (int i = 0; i < 12; i++) v[i].chk = 1;
    v[10].i.done = 1; v[10].i.x = 32'h12345678; v[10].i.y = 32'hFFFF0000;
    v[11].i.rx = 1;
    v[12] = '{i: '{rdy: 1, default: 0}, chk: 1, rvalid: 1, cnt: 1, shots: 1, ox: 1, oy: 0,
              rd: mkrec(16'h1234, 16'hFFFF, 10, 0, 1)};
    v[13] = '{i: '{sclr: 1, default: 0}, chk: 1, rvalid: 0, cnt: 0, shots: 1, ox: 1, oy: 0,
              rd: '0};
    for (int k = 0; k < 4; k++) begin
      v[14+k].i.done = 1;
      v[14+k].i.x = {16'hA000 + 16'(k), 16'h5555};
      v[14+k].i.y = {16'hB000 + 16'(k), 16'h0000};
    end
    v[15].i.rx = 1; v[17].i.rx = 1;
    v[14].chk = 1;
    v[16] = '{i: v[16].i, chk: 1, rvalid: 1, cnt: 1, shots: 1, ox: 1, oy: 0, rd: mkrec(16'hA000, 16'hB000, 14, 0, 1)};
    v[18] = '{i: v[18].i, chk: 1, rvalid: 1, cnt: 3, shots: 3, ox: 2, oy: 0, rd: mkrec(16'hA000, 16'hB000, 14, 0, 1)};
    v[19] = '{i: '{rdy: 1, default: 0}, chk: 1, rvalid: 1, cnt: 4, shots: 4, ox: 2, oy: 0, rd: mkrec(16'hA000, 16'hB000, 14, 0, 1)};
    v[20] = '{i: '{rdy: 1, default: 0}, chk: 1, rvalid: 1, cnt: 3, shots: 4, ox: 2, oy: 0, rd: mkrec(16'hA001, 16'hB001, 15, 0, 0)};
    v[21] = '{i: '{rdy: 1, default: 0}, chk: 1, rvalid: 1, cnt: 2, shots: 4, ox: 2, oy: 0, rd: mkrec(16'hA002, 16'hB002, 16, 0, 1)};
    v[22] = '{i: '{rdy: 1, default: 0}, chk: 1, rvalid: 1, cnt: 1, shots: 4, ox: 2, oy: 0, rd: mkrec(16'hA003, 16'hB003, 17, 0, 0)};
    v[23] = '{i: '{default: 0}, chk: 1, rvalid: 0, cnt: 0, shots: 4, ox: 2, oy: 0, rd: '0};

    do_reset();
    for (int i = 0; i < 24; i++) begin
      if (v[i].chk) begin
        check("tbl_rvalid", 64'(rvalid), 64'(v[i].rvalid));
        check("tbl_count", 64'(count), 64'(v[i].cnt));
        check("tbl_shots", 64'(shots), 64'(v[i].shots));
        check("tbl_onesx", 64'(onesx), 64'(v[i].ox));
        check("tbl_onesy", 64'(onesy), 64'(v[i].oy));
        if (v[i].rvalid) check("tbl_rdata", rdata, vis(v[i].rd));
      end
      step(v[i].i);
    end

    // Overflow: six shots into a four-deep FIFO with no reads.
    cur = '{sclr: 1, default: 0}; step(cur);
    for (int k = 0; k < 6; k++) begin
      cur = '{default: 0};
      cur.done = 1; cur.x = {16'hC000 + 16'(k), 16'h0}; cur.y = $urandom;
      cur.rx = k[0]; cur.ry = 1;
      step(cur);
    end
    cur = '{default: 0}; step(cur); step(cur);
    check("ovf_count", 64'(count), 64'd4);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_dropped", 64'(dropped), 64'd2);
    check("ovf_shots", 64'(shots), 64'd6);
    cur = '{done: 1, default: 0}; cur.x = 32'hC0060000; step(cur);
    cur = '{rdy: 1, rx: 1, default: 0}; step(cur);
    check("full_pop_count", 64'(count), 64'd4);
    check("full_pop_dropped", 64'(dropped), 64'd2);
    check("full_pop_shots", 64'(shots), 64'd7);
    cur = '{rdy: 1, default: 0};
    for (int k = 0; k < 6; k++) step(cur);
    check("drain_count", 64'(count), 64'd0);

    // Empty bypass with rready held high.
    cur = '{done: 1, rdy: 1, default: 0}; step(cur);
    cur = '{rdy: 1, default: 0};
    hits = 0;
    for (int k = 0; k < 6; k++) begin
      if (rvalid) hits++;
      step(cur);
    end
    check("bypass_valid_cycles", 64'(hits), 64'd1);
    check("bypass_count", 64'(count), 64'd0);

    // statclr in the stage-B cycle wins.
    cur = '{done: 1, default: 0}; step(cur);
    cur = '{sclr: 1, rx: 1, ry: 1, default: 0}; step(cur);
    check("statclr_shots", 64'(shots), 64'd0);
    check("statclr_onesx", 64'(onesx), 64'd0);

    // Reset between done and its stage-B cycle discards the capture.
    cur = '{done: 1, default: 0}; step(cur);
    cur = '{rst: 1, rx: 1, default: 0}; step(cur);
    check("rst_count", 64'(count), 64'd0);
    cur = '{default: 0};
    hits = 0;
    for (int k = 0; k < 4; k++) begin
      if (rvalid) hits++;
      step(cur);
    end
    check("rst_no_record", 64'(hits), 64'd0);

    // tsclear in the done cycle stamps the record with zero.
    for (int k = 0; k < 3; k++) step(cur);
    cur = '{done: 1, tclr: 1, default: 0}; step(cur);
    cur = '{ry: 1, default: 0}; step(cur);
    check("tsclear_stamp", 64'(rdata[31:0]), 64'h2);
    cur = '{rdy: 1, default: 0}; step(cur);

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      cur = '{default: 0};
      cur.done = 1'($urandom_range(0, 1));
      cur.x    = $urandom;
      cur.y    = $urandom;
      cur.rx   = 1'($urandom_range(0, 1));
      cur.ry   = 1'($urandom_range(0, 1));
      cur.rdy  = ($urandom_range(0, 9) < 4);
      cur.sclr = ($urandom_range(0, 99) == 0);
      cur.tclr = ($urandom_range(0, 49) == 0);
      cur.rst  = ($urandom_range(0, 299) == 0);
      step(cur);
    end
    cur = '{rdy: 1, default: 0};
    for (int k = 0; k < 8; k++) step(cur);
    check("final_count", 64'(count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
